// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder with a registered sum/carry/overflow result and a valid strobe.
// Optional signed saturation of the registered sum is enabled by defining RIPPLECARRY_SAT_EN.
module ripple_carry_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic             of;
  logic [WIDTH-1:0] res_y;

  logic [WIDTH-1:0] y_q, y_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  // For WIDTH = 1, c[WIDTH-1] is cin, so this also covers the single-bit case.
  assign of = c[WIDTH-1] ^ c[WIDTH];

`ifdef RIPPLECARRY_SAT_EN
  // Overflow implies equal operand MSBs; clamp toward the sign of A.
  always_comb begin
    res_y = s;
    if (of) begin
      res_y          = {WIDTH{~A[WIDTH-1]}};
      res_y[WIDTH-1] = A[WIDTH-1];
    end
  end
`else
  assign res_y = s;
`endif

  always_comb begin
    y_d     = y_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = in_valid;
    if (in_valid) begin
      y_d    = res_y;
      cout_d = c[WIDTH];
      ovf_d  = of;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign y         = y_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder: the driver queues expected results from an
// arithmetic reference model, and a negedge monitor pops and compares them.
module tb_ripple_carry_adder;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] y;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic [W-1:0] y;
  logic         cout;
  logic         ovf;
  logic         out_valid;

  int   checks;
  int   errors;
  res_t exp_q[$];
  res_t last;

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (a_in),
    .B         (b_in),
    .cin       (cin),
    .y         (y),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from plain integer arithmetic on unsigned and signed views.
  function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic c);
    res_t r;
    int   ua, ub, full, sa, sb, ss, smax, smin;
    ua   = int'(a);
    ub   = int'(b);
    full = ua + ub + int'(c);
    r.y    = W'(full);
    r.cout = (full >= (1 << W));
    sa   = a[W-1] ? ua - (1 << W) : ua;
    sb   = b[W-1] ? ub - (1 << W) : ub;
    ss   = sa + sb + int'(c);
    smax = (1 << (W - 1)) - 1;
    smin = -(1 << (W - 1));
    r.ovf = (ss > smax) || (ss < smin);
`ifdef RIPPLECARRY_SAT_EN
    if (r.ovf) r.y = (ss > smax) ? W'(smax) : W'(smin);
`endif
    return r;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; expected result is queued once the edge has sampled it.
  task automatic drive(logic v, logic [W-1:0] a, logic [W-1:0] b, logic c);
    in_valid = v;
    a_in     = a;
    b_in     = b;
    cin      = c;
    @(posedge clk);
    if (v && rst_n) exp_q.push_back(model(a, b, c));
    #1;
  endtask

  task automatic check_zero(string name);
    check({name, "_y"}, int'(y), 0);
    check({name, "_cout"}, int'(cout), 0);
    check({name, "_ovf"}, int'(ovf), 0);
    check({name, "_valid"}, int'(out_valid), 0);
  endtask

  // Monitor: at most one result is outstanding at each negedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check_zero("in_reset");
    end else if (exp_q.size() > 0) begin
      res_t e;
      e = exp_q.pop_front();
      check("out_valid_set", int'(out_valid), 1);
      check("sum_y", int'(y), int'(e.y));
      check("sum_cout", int'(cout), int'(e.cout));
      check("sum_ovf", int'(ovf), int'(e.ovf));
      last = e;
    end else begin
      check("out_valid_clear", int'(out_valid), 0);
      check("hold_y", int'(y), int'(last.y));
      check("hold_cout", int'(cout), int'(last.cout));
      check("hold_ovf", int'(ovf), int'(last.ovf));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    last     = '0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a_in     = '0;
    b_in     = '0;
    cin      = 1'b0;
    #3;
    check_zero("reset_initial");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Directed vectors
    drive(1'b1, 4'b0010, 4'b0011, 1'b0);
    drive(1'b1, 4'b1010, 4'b0011, 1'b0);
    drive(1'b1, 4'b1111, 4'b0111, 1'b0);
    drive(1'b1, 4'b0010, 4'b0101, 1'b1);

    // Hold: operands change while in_valid is low
    for (int i = 0; i < 3; i++) drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));

    // Asynchronous reset between edges clears outputs at once
    #1 rst_n = 1'b0;
    exp_q.delete();
    last = '0;
    #1 check_zero("async_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Back-to-back throughput ending in -8 + -8
    drive(1'b1, 4'b0111, 4'b0001, 1'b0);
    drive(1'b1, 4'b0110, 4'b1001, 1'b1);
    drive(1'b1, 4'b1100, 4'b1011, 1'b0);
    drive(1'b1, 4'b1000, 4'b1000, 1'b0);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Reset before the sampling edge discards a pending operand set
    in_valid = 1'b1;
    a_in     = 4'b0101;
    b_in     = 4'b0101;
    #1 rst_n = 1'b0;
    exp_q.delete();
    last = '0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Randomized traffic, mostly valid
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom));
    end
    repeat (3) drive(1'b0, 4'b0000, 4'b0000, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder.md
Name: ripple_carry_adder

Overview:
- WIDTH-bit two's-complement/unsigned adder built from a chain of WIDTH single-bit full adders; carry ripples from bit 0 to bit WIDTH-1.
- Sum, carry-out and signed-overflow flag are captured in an output register with a valid strobe.
- Used as the adder slice of the ALU datapath.

Parameters:
- WIDTH, 4, operand and sum width in bits. Legal for any WIDTH >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle; result is captured on this edge
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- cin  input  1  carry into bit 0
- y  output  WIDTH  registered sum, (A + B + cin) mod 2^WIDTH
- cout  output  1  registered carry out of bit WIDTH-1
- ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB
- out_valid  output  1  high for one cycle when y/cout/ovf hold a new result

Behaviour:
- Structure:
  - Generate WIDTH full adders: s[i] = A[i]^B[i]^c[i]; c[i+1] = A[i]&B[i] | c[i]&(A[i]^B[i]); c[0] = cin.
  - No carry-lookahead; the critical path is the full ripple chain.
- Combinational result: sum = s; co = c[WIDTH]; of = c[WIDTH-1]^c[WIDTH]. For WIDTH = 1, of = cin ^ co.
- Reset:
  - rst_n low asynchronously forces y = 0, cout = 0, ovf = 0, out_valid = 0, regardless of clk.
  - On release, outputs stay 0 until the first accepted in_valid.
- Latency: 1 cycle. If in_valid = 1 at rising edge N, then after edge N:
  - y, cout and ovf show the result for the operands sampled at edge N;
  - out_valid = 1.
- If in_valid = 0 at an edge:
  - y, cout and ovf hold their previous values;
  - out_valid = 0.
- Back-to-back in_valid is accepted every cycle with no stall and no backpressure.
- Reset asserted mid-stream discards any result not yet presented; no output appears after reset until a new in_valid.
- Wrap-around: the sum is modulo 2^WIDTH. Carry beyond bit WIDTH-1 appears only on cout.
- A, B and cin are interpreted identically for signed and unsigned use. Only the ovf meaning is signed.
- X/Z on the inputs while in_valid = 0 must not corrupt the held outputs.

Optional Feature:
- Macro: RIPPLECARRY_SAT_EN.
- When defined, the registered y is saturated on signed overflow:
  - ovf with both operand MSBs 0 gives y = 0 followed by all ones (most positive value);
  - ovf with both operand MSBs 1 gives y = 1 followed by all zeros (most negative value).
- cout and ovf are unchanged by saturation. With no overflow, y is the plain sum.
- When not defined, y is always the wrapped sum. This is the default build.

Test Plan (WIDTH = 4, macro undefined unless stated; each case applied with in_valid = 1, outputs checked one cycle later):
- A=0010, B=0011, cin=0 (2+3) -> y=0101, cout=0, ovf=0, out_valid=1.
- A=1010, B=0011, cin=0 (-6+3) -> y=1101, cout=0, ovf=0.
- A=1111, B=0111, cin=0 (-1+7) -> y=0110, cout=1, ovf=0.
- A=0010, B=0101, cin=1 (2+5+1) -> y=1000, cout=0, ovf=1. With RIPPLECARRY_SAT_EN defined: y=0111.
- Hold and valid check: after one valid result, drive in_valid=0 and change A/B for 3 cycles -> y is unchanged and out_valid=0. Then assert rst_n=0 between clock edges -> all outputs read 0 immediately.
- Throughput: drive 4 consecutive valid vectors, including A=1000, B=1000, cin=0 (-8+-8) -> one result per cycle in order; the last gives y=0000, cout=1, ovf=1 (y=1000 under RIPPLECARRY_SAT_EN).
